// File: rtl/alu_exec_unit.sv
// RV32I R-type execute unit: NUM_REGS x DATA_WIDTH register file, ALU and write-back FSM.
// Shifts iterate one bit per cycle unless ALU_EXEC_FAST_SHIFT_EN selects a barrel shifter.
module alu_exec_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   localparam int ADDR_W    = $clog2(NUM_REGS),
   localparam int SHAMT_W   = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [6:0]            funct7,
   input  logic [2:0]            funct3,
   input  logic [ADDR_W-1:0]     rs1,
   input  logic [ADDR_W-1:0]     rs2,
   input  logic [ADDR_W-1:0]     rd,
   input  logic                  dbg_we,
   input  logic [ADDR_W-1:0]     dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  overflow,
   output logic                  zero,
   output logic                  error
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_WB    = 2'd3;
   localparam int MSB = DATA_WIDTH - 1;

   // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
   // in_ready is high only in IDLE and in_valid must hold its fields until that edge.
   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [DATA_WIDTH-1:0] opa_q, opb_q;
   logic [ADDR_W-1:0]     rd_q;
   logic [6:0]            f7_q;
   logic [2:0]            f3_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  overflow_q, zero_q, error_q;

   logic [SHAMT_W-1:0]    shamt;
   logic [DATA_WIDTH-1:0] sum, diff;
   logic [DATA_WIDTH-1:0] shl_res, srl_res, sra_res;
   logic [DATA_WIDTH-1:0] exec_res;
   logic                  exec_ovf, exec_err, exec_shift;

   assign shamt = opb_q[SHAMT_W-1:0];
   assign sum   = opa_q + opb_q;
   assign diff  = opa_q - opb_q;

`ifdef ALU_EXEC_FAST_SHIFT_EN
   assign shl_res = opa_q << shamt;
   assign srl_res = opa_q >> shamt;
   assign sra_res = DATA_WIDTH'($signed(opa_q) >>> shamt);
`else
   // Iterative mode: EXEC only needs the shift-by-zero value; SHIFT produces the rest.
   logic [DATA_WIDTH-1:0] acc_q, acc_shifted;
   logic [SHAMT_W-1:0]    cnt_q;

   assign shl_res = opa_q;
   assign srl_res = opa_q;
   assign sra_res = opa_q;

   always_comb begin
      acc_shifted = {f7_q[5] & acc_q[MSB], acc_q[MSB:1]};
      if (f3_q == 3'd1) acc_shifted = {acc_q[MSB-1:0], 1'b0};
   end
`endif

   always_comb begin
      exec_res   = '0;
      exec_ovf   = 1'b0;
      exec_err   = 1'b0;
      exec_shift = 1'b0;
      case ({f7_q, f3_q})
         {7'h00, 3'd0}: begin
            exec_res = sum;
            exec_ovf = (opa_q[MSB] == opb_q[MSB]) && (sum[MSB] != opa_q[MSB]);
         end
         {7'h20, 3'd0}: begin
            exec_res = diff;
            exec_ovf = (opa_q[MSB] != opb_q[MSB]) && (diff[MSB] != opa_q[MSB]);
         end
         {7'h00, 3'd1}: begin exec_shift = 1'b1; exec_res = shl_res; end
         {7'h00, 3'd2}: exec_res = {{(DATA_WIDTH-1){1'b0}}, $signed(opa_q) < $signed(opb_q)};
         {7'h00, 3'd3}: exec_res = {{(DATA_WIDTH-1){1'b0}}, opa_q < opb_q};
         {7'h00, 3'd4}: exec_res = opa_q ^ opb_q;
         {7'h00, 3'd5}: begin exec_shift = 1'b1; exec_res = srl_res; end
         {7'h20, 3'd5}: begin exec_shift = 1'b1; exec_res = sra_res; end
         {7'h00, 3'd6}: exec_res = opa_q | opb_q;
         {7'h00, 3'd7}: exec_res = opa_q & opb_q;
         default:       exec_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         opa_q      <= '0;
         opb_q      <= '0;
         rd_q       <= '0;
         f7_q       <= '0;
         f3_q       <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
         error_q    <= 1'b0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
         acc_q      <= '0;
         cnt_q      <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (in_valid) begin
               opa_q <= regs[rs1];
               opb_q <= regs[rs2];
               rd_q  <= rd;
               f7_q  <= funct7;
               f3_q  <= funct3;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
`ifndef ALU_EXEC_FAST_SHIFT_EN
               acc_q <= opa_q;
               cnt_q <= shamt;
               if (exec_shift && shamt != '0) state <= ST_SHIFT;
               else begin
`else
               begin
`endif
                  result_q   <= exec_res;
                  overflow_q <= exec_ovf;
                  zero_q     <= (exec_res == '0);
                  error_q    <= exec_err;
                  state      <= ST_WB;
               end
            end
`ifndef ALU_EXEC_FAST_SHIFT_EN
            ST_SHIFT: begin
               acc_q <= acc_shifted;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == SHAMT_W'(1)) begin
                  result_q   <= acc_shifted;
                  overflow_q <= 1'b0;
                  zero_q     <= (acc_shifted == '0);
                  error_q    <= 1'b0;
                  state      <= ST_WB;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (state == ST_WB) begin
         if (!error_q && rd_q != '0) regs[rd_q] <= result_q;
      end else if (state == ST_IDLE && dbg_we && dbg_addr != '0) begin
         regs[dbg_addr] <= dbg_wdata;
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign done      = (state == ST_WB);
   assign dbg_rdata = regs[dbg_addr];
   assign result    = result_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;
   assign error     = error_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised register-file plus ALU execute unit for RV32I R-type instructions.
- Accepts one decoded R-type instruction per valid/ready handshake, reads rs1/rs2 from an internal NUM_REGS-entry register file, executes, then writes the result back to rd.
- Shifts run iteratively by default, one bit per cycle.
- Sits between the decode stage and the rest of the datapath; a debug port preloads and inspects registers.

Parameters:
- DATA_WIDTH, 32, operand/register width; must be a power of two, at least 8.
- NUM_REGS, 32, register count; must be a power of two; entry 0 is hardwired to zero.
- ADDR_W, $clog2(NUM_REGS), register index width (derived).
- SHAMT_W, $clog2(DATA_WIDTH), shift amount width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  unit idle and able to accept.
- funct7  in  7  R-type funct7.
- funct3  in  3  R-type funct3.
- rs1  in  ADDR_W  source register A.
- rs2  in  ADDR_W  source register B.
- rd  in  ADDR_W  destination register.
- dbg_we  in  1  debug register write enable.
- dbg_addr  in  ADDR_W  debug write/read index.
- dbg_wdata  in  DATA_WIDTH  debug write data.
- dbg_rdata  out  DATA_WIDTH  combinational read of reg[dbg_addr].
- done  out  1  one-cycle retire pulse.
- result  out  DATA_WIDTH  retired result, held until the next retire.
- overflow  out  1  signed overflow of the retired add/sub.
- zero  out  1  retired result equals 0.
- error  out  1  retired instruction had an illegal encoding.

Behaviour:
- Reset (async, any state): state=IDLE; all registers 0; result=0; overflow=zero=error=done=0. in_ready=1 once rst deasserts.
- States are IDLE, EXEC, SHIFT, WB. in_ready=1 only in IDLE.
- IDLE: on in_valid&in_ready, latch opA=reg[rs1], opB=reg[rs2], rd, funct7, funct3 -> EXEC.
- EXEC:
  - Decode per RV32I: add 0/0, sub 0x20/0, sll 0/1, slt 0/2, sltu 0/3, xor 0/4, srl 0/5, sra 0x20/5, or 0/6, and 0/7 (funct7/funct3).
  - Any other pair sets the error flag and goes to WB with result 0.
  - Non-shift ops compute in one cycle -> WB.
  - Shift ops load cnt=opB[SHAMT_W-1:0] and acc=opA. If cnt==0 -> WB; else -> SHIFT.
- SHIFT: each cycle shift acc by 1 (sll: zero fill; srl: zero fill; sra: sign fill) and decrement cnt. When cnt reaches 0 -> WB.
- WB:
  - done=1; result/overflow/zero/error registered.
  - reg[rd] written at the end of the cycle unless rd==0 or error -> IDLE.
- Latency from accept to done: 2 cycles for non-shift ops; 2+shamt cycles for shifts.
- Arithmetic:
  - add/sub wrap modulo 2^DATA_WIDTH.
  - overflow is set only for add/sub on signed overflow, otherwise 0.
  - slt/sltu return 1 or 0, zero-extended.
  - Shift amount uses only the low SHAMT_W bits of opB.
- Register 0 always reads 0; all writes to it are dropped, including debug writes.
- Debug write:
  - Honoured only in IDLE and ignored otherwise.
  - If dbg_we and an accept happen in the same cycle, the operands take the pre-write values; the debug write still completes.
- No bypass needed: only one instruction is in flight, and its write-back completes before the next accept.
- done is low in every state except WB.
- Reset during SHIFT/WB aborts the instruction: no write-back, no done.

Optional Feature:
- Macro ALU_EXEC_FAST_SHIFT_EN.
- Defined: shifts complete in EXEC with a barrel shifter; the SHIFT state is unused/removed; every legal op has 2-cycle latency.
- Undefined: iterative shifting as described above.

Test Plan:
- Debug preload reg1=0x7FFFFFFF, reg2=0x00000001; add rd=5 -> done 2 cycles after accept, result=0x80000000, overflow=1, zero=0, reg5=0x80000000 via dbg_rdata.
- Preload reg1=5, reg2=5; sub rd=6 -> result=0, zero=1, overflow=0. Then slt rd=7 with reg1=0xFFFFFFFF, reg2=1 -> 1; sltu with the same operands -> 0.
- reg1=0x80000000, reg2=0x00000024 (shamt=4):
  - sra -> 0xF8000000, done 6 cycles after accept (2 cycles with ALU_EXEC_FAST_SHIFT_EN); in_ready stays low throughout.
  - srl -> 0x08000000.
- funct7=0x20, funct3=1 -> error=1, result=0, rd unchanged. Any op with rd=0 -> done pulses, reg0 reads 0.
- Assert rst in the SHIFT state -> in_ready=1 and done=0 next cycle; all dbg_rdata return 0; no write-back.
- Back-to-back in_valid held high: the second instruction is accepted on the cycle after done and reads the first instruction's written rd value.
